// File: rtl/exe_stage_pkg.sv
// Shared constants for the execute stage: EXE_CMD opcodes, forward-select codes, MUL/DIV FSM states.
package exe_stage_pkg;

  localparam logic [3:0] EXE_ADD = 4'b0000;
  localparam logic [3:0] EXE_SUB = 4'b0010;
  localparam logic [3:0] EXE_AND = 4'b0100;
  localparam logic [3:0] EXE_OR  = 4'b0101;
  localparam logic [3:0] EXE_NOR = 4'b0110;
  localparam logic [3:0] EXE_XOR = 4'b0111;
  localparam logic [3:0] EXE_SLL = 4'b1000;
  localparam logic [3:0] EXE_SRA = 4'b1001;
  localparam logic [3:0] EXE_SRL = 4'b1010;
  localparam logic [3:0] EXE_MUL = 4'b1100;
  localparam logic [3:0] EXE_DIV = 4'b1101;

  localparam logic [1:0] FWD_ID  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/exe_stage_if.sv
// ID/EXE -> EXE/MEM bundle of the execute stage; master drives operands, slave is exe_stage.
interface exe_stage_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       EXE_CMD;
  logic [WIDTH-1:0] val1;
  logic [WIDTH-1:0] val2;
  logic [WIDTH-1:0] imm_val;
  logic             is_imm;
  logic [1:0]       forward_signal_mux_1;
  logic [1:0]       forward_signal_mux_2_3;
  logic [WIDTH-1:0] MEM_ALU_result;
  logic [WIDTH-1:0] WB_value;
  logic             EXE_flush;
  logic [WIDTH-1:0] ALU_result;
  logic [WIDTH-1:0] ST_val;
  logic             exe_stall;
  logic             md_busy;

  modport master (
    output EXE_CMD, val1, val2, imm_val, is_imm,
    output forward_signal_mux_1, forward_signal_mux_2_3,
    output MEM_ALU_result, WB_value, EXE_flush,
    input  ALU_result, ST_val, exe_stall, md_busy
  );

  modport slave (
    input  EXE_CMD, val1, val2, imm_val, is_imm,
    input  forward_signal_mux_1, forward_signal_mux_2_3,
    input  MEM_ALU_result, WB_value, EXE_flush,
    output ALU_result, ST_val, exe_stall, md_busy
  );
endinterface

// File: rtl/exe_stage_muldiv.sv
// Iterative signed MUL (and DIV when EXE_DIV_EN is defined): magnitude shift-add/subtract, sign fixed at end.
// Latency: stall WIDTH+1 cycles (start + WIDTH BUSY), result visible in the single DONE cycle.
// Backpressure: stall freezes upstream; flush aborts in any state and drops stall immediately.
module exe_stage_muldiv
  import exe_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic             flush,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (-v) : v;
  endfunction

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] result_q;
  logic             neg_q;
  logic             start;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] opa_nxt;
  logic [WIDTH-1:0] opb_nxt;
  logic [WIDTH-1:0] mag_res;
  logic [WIDTH-1:0] res_fix;

`ifdef EXE_DIV_EN
  logic             is_div_q;
  logic             divz_q;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;
`endif

  assign start = start_mul | start_div;

  // MUL: acc += opa when opb lsb set. DIV: acc is the remainder, opa shifts dividend out / quotient in.
  always_comb begin
    acc_nxt = acc_q + (opb_q[0] ? opa_q : '0);
    opa_nxt = opa_q << 1;
    opb_nxt = opb_q >> 1;
`ifdef EXE_DIV_EN
    rem_sh  = {acc_q, opa_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, opb_q};
    if (is_div_q) begin
      opb_nxt = opb_q;
      if (!rem_sub[WIDTH]) begin
        acc_nxt = rem_sub[WIDTH-1:0];
        opa_nxt = {opa_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = rem_sh[WIDTH-1:0];
        opa_nxt = {opa_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_comb begin
    mag_res = acc_nxt;
`ifdef EXE_DIV_EN
    if (is_div_q) mag_res = opa_nxt;
`endif
    res_fix = neg_q ? (-mag_res) : mag_res;
`ifdef EXE_DIV_EN
    if (is_div_q && divz_q) res_fix = '1;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= MD_IDLE;
      cnt      <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
`ifdef EXE_DIV_EN
      is_div_q <= 1'b0;
      divz_q   <= 1'b0;
`endif
    end else if (flush) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            state <= MD_BUSY;
            cnt   <= '0;
            acc_q <= '0;
            opa_q <= mag(op1);
            opb_q <= mag(op2);
            neg_q <= op1[WIDTH-1] ^ op2[WIDTH-1];
`ifdef EXE_DIV_EN
            is_div_q <= start_div;
            divz_q   <= (op2 == '0);
`endif
          end
        end
        MD_BUSY: begin
          acc_q <= acc_nxt;
          opa_q <= opa_nxt;
          opb_q <= opb_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= MD_DONE;
            result_q <= res_fix;
          end
        end
        // DONE never restarts: the instruction still sitting in EXE is the one just finished.
        MD_DONE: state <= MD_IDLE;
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign stall  = rst & ~flush & (((state == MD_IDLE) & start) | (state == MD_BUSY));
  assign busy   = (state == MD_BUSY);
  assign done   = (state == MD_DONE);
  assign result = result_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: forwarding muxes, single-cycle ALU, iterative MUL (DIV only with EXE_DIV_EN defined).
// Latency: ALU ops 0 cycles; MUL/DIV stall WIDTH+1 cycles, result in DONE cycle.
// Backpressure: exe_stall freezes IF/ID/EXE and bubbles EXE/MEM; EXE_flush aborts MUL/DIV.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  exe_stage_if.slave bus
);

  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] rt;
  logic [WIDTH-1:0] op2;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] alu_res;
  logic             start_mul;
  logic             start_div;
  logic             md_stall;
  logic             md_busy_w;
  logic             md_done;
  logic [WIDTH-1:0] md_result;

  always_comb begin
    case (bus.forward_signal_mux_1)
      FWD_ID:  op1 = bus.val1;
      FWD_MEM: op1 = bus.MEM_ALU_result;
      FWD_WB:  op1 = bus.WB_value;
      default: op1 = bus.val1;
    endcase
    case (bus.forward_signal_mux_2_3)
      FWD_ID:  rt = bus.val2;
      FWD_MEM: rt = bus.MEM_ALU_result;
      FWD_WB:  rt = bus.WB_value;
      default: rt = bus.val2;
    endcase
  end

  assign op2   = bus.is_imm ? bus.imm_val : rt;
  assign shamt = op2[4:0];

  // MUL/DIV codes fall to the default here; their result comes from the engine's DONE cycle.
  always_comb begin
    alu_res = '0;
    case (bus.EXE_CMD)
      EXE_ADD: alu_res = op1 + op2;
      EXE_SUB: alu_res = op1 - op2;
      EXE_AND: alu_res = op1 & op2;
      EXE_OR:  alu_res = op1 | op2;
      EXE_NOR: alu_res = ~(op1 | op2);
      EXE_XOR: alu_res = op1 ^ op2;
      EXE_SLL: alu_res = op1 << shamt;
      EXE_SRL: alu_res = op1 >> shamt;
      EXE_SRA: alu_res = $unsigned($signed(op1) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  assign start_mul = (bus.EXE_CMD == EXE_MUL);
`ifdef EXE_DIV_EN
  assign start_div = (bus.EXE_CMD == EXE_DIV);
`else
  assign start_div = 1'b0;
`endif

  exe_stage_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start_mul(start_mul),
    .start_div(start_div),
    .flush    (bus.EXE_flush),
    .op1      (op1),
    .op2      (op2),
    .stall    (md_stall),
    .busy     (md_busy_w),
    .done     (md_done),
    .result   (md_result)
  );

  assign bus.ALU_result = md_done ? md_result : alu_res;
  assign bus.ST_val     = rt;
  assign bus.exe_stall  = md_stall;
  assign bus.md_busy    = md_busy_w;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: ALU/forwarding vector table plus MUL/DIV, flush and reset sequences.
module tb_exe_stage;
  import exe_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  exe_stage_if #(.WIDTH(32)) bus ();

  exe_stage #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic        is_imm;
    logic [1:0]  m1;
    logic [1:0]  m23;
    logic [31:0] exp_alu;
    logic [31:0] exp_st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                              input logic [31:0] imm, input logic is_imm, input logic [1:0] m1,
                              input logic [1:0] m23, input logic [31:0] exp_alu,
                              input logic [31:0] exp_st);
    vec_t v;
    v.cmd = cmd; v.v1 = v1; v.v2 = v2; v.imm = imm; v.is_imm = is_imm;
    v.m1 = m1; v.m23 = m23; v.exp_alu = exp_alu; v.exp_st = exp_st;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ops(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2);
    bus.EXE_CMD = cmd;
    bus.val1 = v1;
    bus.val2 = v2;
    bus.imm_val = 32'd0;
    bus.is_imm = 1'b0;
    bus.forward_signal_mux_1 = FWD_ID;
    bus.forward_signal_mux_2_3 = FWD_ID;
    bus.EXE_flush = 1'b0;
  endtask

  // Starts from IDLE with the operation already driven; returns in the DONE cycle.
  task automatic run_md(input string name, input logic [31:0] exp, input bit toggle);
    int stall_cnt = 0;
    int busy_cnt = 0;
    bit ended = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!bus.exe_stall) begin
        ended = 1'b1;
        break;
      end
      stall_cnt++;
      if (bus.md_busy) busy_cnt++;
      if (toggle && busy_cnt == 3) begin
        bus.forward_signal_mux_1 = FWD_MEM;
        bus.forward_signal_mux_2_3 = FWD_WB;
      end
      tick();
    end
    check({name, "_ended"}, 32'(ended), 32'd1);
    check({name, "_stall_cycles"}, stall_cnt, 32'd33);
    check({name, "_busy_cycles"}, busy_cnt, 32'd32);
    check({name, "_result"}, bus.ALU_result, exp);
    check({name, "_busy_in_done"}, 32'(bus.md_busy), 32'd0);
  endtask

  task automatic md_case(input string name, input logic [3:0] cmd, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [31:0] exp);
    set_ops(cmd, v1, v2);
    run_md(name, exp, 1'b0);
    tick();
    set_ops(EXE_ADD, 32'd2, 32'd3);
    #1;
    check({name, "_idle_busy"}, 32'(bus.md_busy), 32'd0);
    check({name, "_idle_stall"}, 32'(bus.exe_stall), 32'd0);
    check({name, "_idle_alu"}, bus.ALU_result, 32'd5);
    tick();
  endtask

  initial begin
    int bad;
    rst_n = 1'b0;
    set_ops(EXE_MUL, 32'hFFFF_FFFD, 32'd7);
    bus.MEM_ALU_result = 32'd7;
    bus.WB_value = 32'd9;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_stall", 32'(bus.exe_stall), 32'd0);
    check("reset_busy", 32'(bus.md_busy), 32'd0);
    set_ops(EXE_ADD, 32'd0, 32'd0);
    tick();
    rst_n = 1'b1;

    vecs.push_back(mk(EXE_ADD, 32'd5, 32'd1, 32'd0, 1'b0, 2'd1, 2'd0, 32'd8, 32'd1));
    vecs.push_back(mk(EXE_ADD, 32'd5, 32'd1, 32'd0, 1'b0, 2'd2, 2'd0, 32'd10, 32'd1));
    vecs.push_back(mk(EXE_ADD, 32'd5, 32'd1, 32'd3, 1'b1, 2'd0, 2'd2, 32'd8, 32'd9));
    vecs.push_back(mk(EXE_ADD, 32'd5, 32'd1, 32'd0, 1'b0, 2'd3, 2'd1, 32'd12, 32'd7));
    vecs.push_back(mk(EXE_SUB, 32'd0, 32'd1, 32'd0, 1'b0, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'd1));
    vecs.push_back(mk(EXE_SRA, 32'h8000_0000, 32'd31, 32'd0, 1'b0, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'd31));
    vecs.push_back(mk(EXE_NOR, 32'd0, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'd0));
    vecs.push_back(mk(EXE_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 1'b0, 2'd0, 2'd0, 32'h00F0_00F0, 32'h0FF0_0FF0));
    vecs.push_back(mk(EXE_OR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 1'b0, 2'd0, 2'd0, 32'hFFF0_FFF0, 32'h0FF0_0FF0));
    vecs.push_back(mk(EXE_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 1'b0, 2'd0, 2'd0, 32'hFF00_FF00, 32'h0FF0_0FF0));
    vecs.push_back(mk(EXE_SLL, 32'd1, 32'h24, 32'd0, 1'b0, 2'd0, 2'd0, 32'h10, 32'h24));
    vecs.push_back(mk(EXE_SRL, 32'h8000_0000, 32'd31, 32'd0, 1'b0, 2'd0, 2'd0, 32'd1, 32'd31));
    vecs.push_back(mk(EXE_ADD, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 2'd0, 2'd0, 32'd1, 32'd2));
    vecs.push_back(mk(4'b0011, 32'd5, 32'd1, 32'd0, 1'b0, 2'd0, 2'd0, 32'd0, 32'd1));
    vecs.push_back(mk(EXE_SUB, 32'd10, 32'd100, 32'hFFFF_FFFF, 1'b1, 2'd0, 2'd0, 32'd11, 32'd100));

    foreach (vecs[i]) begin
      bus.EXE_CMD = vecs[i].cmd;
      bus.val1 = vecs[i].v1;
      bus.val2 = vecs[i].v2;
      bus.imm_val = vecs[i].imm;
      bus.is_imm = vecs[i].is_imm;
      bus.forward_signal_mux_1 = vecs[i].m1;
      bus.forward_signal_mux_2_3 = vecs[i].m23;
      #1;
      check($sformatf("vec%0d_alu", i), bus.ALU_result, vecs[i].exp_alu);
      check($sformatf("vec%0d_st", i), bus.ST_val, vecs[i].exp_st);
      check($sformatf("vec%0d_stall", i), 32'(bus.exe_stall), 32'd0);
      tick();
    end

    // MUL -3*7 with forward selects moved mid-BUSY (they would give 7*9 if not frozen)
    set_ops(EXE_MUL, 32'hFFFF_FFFD, 32'd7);
    run_md("mul_m3x7", 32'hFFFF_FFEB, 1'b1);
    tick();
    set_ops(EXE_ADD, 32'd2, 32'd3);
    #1;
    check("mul_next_busy", 32'(bus.md_busy), 32'd0);
    check("mul_next_stall", 32'(bus.exe_stall), 32'd0);
    check("mul_next_alu", bus.ALU_result, 32'd5);
    tick();

    // Back-to-back MULs: the second starts straight after the single DONE cycle
    set_ops(EXE_MUL, 32'd2, 32'd3);
    run_md("b2b_first", 32'd6, 1'b0);
    tick();
    set_ops(EXE_MUL, 32'hFFFF_FFFC, 32'hFFFF_FFFB);
    run_md("b2b_second", 32'd20, 1'b0);
    tick();
    set_ops(EXE_ADD, 32'd0, 32'd0);
    tick();

    md_case("mul_min_x_m1", EXE_MUL, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);

`ifdef EXE_DIV_EN
    md_case("div_m7_2", EXE_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    md_case("div_5_0", EXE_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
    md_case("div_min_m1", EXE_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
`else
    set_ops(EXE_DIV, 32'd5, 32'd1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.exe_stall || bus.md_busy || bus.ALU_result !== 32'd0) bad++;
      tick();
    end
    check("nodiv_single_cycle_zero", bad, 32'd0);
`endif

    // Flush at BUSY cycle 10
    set_ops(EXE_MUL, 32'hFFFF_FFFD, 32'd7);
    #1;
    check("flush_start_stall", 32'(bus.exe_stall), 32'd1);
    tick();
    repeat (9) tick();
    bus.EXE_flush = 1'b1;
    #1;
    check("flush_stall_same_cycle", 32'(bus.exe_stall), 32'd0);
    check("flush_still_busy", 32'(bus.md_busy), 32'd1);
    tick();
    set_ops(EXE_ADD, 32'd2, 32'd3);
    #1;
    check("flush_idle_busy", 32'(bus.md_busy), 32'd0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      #1;
      if (bus.md_busy || bus.exe_stall || bus.ALU_result !== 32'd5) bad++;
    end
    check("flush_no_done", bad, 32'd0);
    tick();

    // Flush wins over start
    set_ops(EXE_MUL, 32'd2, 32'd3);
    bus.EXE_flush = 1'b1;
    #1;
    check("flush_vs_start_stall", 32'(bus.exe_stall), 32'd0);
    tick();
    set_ops(EXE_ADD, 32'd2, 32'd3);
    #1;
    check("flush_vs_start_busy", 32'(bus.md_busy), 32'd0);
    tick();

    // Reset at BUSY cycle 5
    set_ops(EXE_MUL, 32'hFFFF_FFFD, 32'd7);
    tick();
    repeat (4) tick();
    #1;
    check("rst_mid_busy_before", 32'(bus.md_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(bus.md_busy), 32'd0);
    check("rst_mid_stall", 32'(bus.exe_stall), 32'd0);
    check("rst_mid_alu", bus.ALU_result, 32'd0);
    set_ops(EXE_ADD, 32'd4, 32'd4);
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_release_busy", 32'(bus.md_busy), 32'd0);
    check("rst_release_alu", bus.ALU_result, 32'd8);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
